// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared types for the multi-cycle shifter: the 2-bit shift-mode encoding
// presented by the control unit and the shifter FSM state encoding.
// -----------------------------------------------------------------------------
package shift_pkg;

    // Encoding matches the 2-bit mode field driven by the control unit.
    typedef enum logic [1:0] {
        SHR  = 2'b00,   // logical right
        SHRA = 2'b01,   // arithmetic right, sign replicated
        SHL  = 2'b10,   // logical left
        SHC  = 2'b11    // rotate left
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// One bounded barrel stage: shifts data by k positions (0 <= k <= STEP) in the
// requested mode. Purely combinational.
//
// Ports:
//   data   in  w     operand before this cycle's shift
//   k      in  KW    shift amount, never larger than STEP
//   mode   in  2     shift_mode_t selecting SHR / SHRA / SHL / SHC
//   result out w     shifted operand
// -----------------------------------------------------------------------------
module shift_step
    import shift_pkg::*;
#(
    parameter int w    = 32,
    parameter int STEP = 1,
    parameter int KW   = $clog2(STEP + 1)
) (
    input  logic [w-1:0]  data,
    input  logic [KW-1:0] k,
    input  shift_mode_t   mode,
    output logic [w-1:0]  result
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case can leave it unassigned and infer a latch.
        result = data;
        unique case (mode)
            SHR:  result = data >> k;
            // Fill bits come from data[w-1] of the incoming word, so a k > 1
            // step behaves exactly like k single-bit arithmetic shifts.
            SHRA: result = $signed(data) >>> k;
            SHL:  result = data << k;
            // k == w gives data >> 0 on the right term, i.e. a full rotation
            // back to the original word; k == 0 gives data >> w == 0.
            SHC:  result = (data << k) | (data >> (w - int'(k)));
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// -----------------------------------------------------------------------------
// shift_unit
// Multi-cycle shifter for the RISC datapath. Operand and count registers are
// loaded from the shared tri-state bus; after start, the operand is shifted by
// up to STEP positions per clock until the count reaches zero, then a one-cycle
// done pulse is issued. The result is returned to the bus on drive.
//
// Ports:
//   clk        in     1   system clock, rising edge
//   rst        in     1   asynchronous active-high reset
//   bus        inout  w   shared tri-state datapath bus
//   ld_data    in     1   capture bus into operand register
//   ld_cnt     in     1   capture bus[CW-1:0] into count register
//   mode       in     2   shift mode, sampled on start
//   start      in     1   begin shifting (single-cycle pulse)
//   drive      in     1   drive operand register onto bus when not busy
//   busy       out    1   high while shifting
//   done       out    1   one-cycle pulse when the result is valid
//   n          out    1   count register == 0
//   tb_shifts  out    CW  current count value
// -----------------------------------------------------------------------------
module shift_unit
    import shift_pkg::*;
#(
    parameter int w    = 32,
    parameter int STEP = 1,
    parameter int CW   = $clog2(w)
) (
    input  logic          clk,
    input  logic          rst,
    inout  wire  [w-1:0]  bus,
    input  logic          ld_data,
    input  logic          ld_cnt,
    input  logic [1:0]    mode,
    input  logic          start,
    input  logic          drive,
    output logic          busy,
    output logic          done,
    output logic          n,
    output logic [CW-1:0] tb_shifts
);

    localparam int KW = $clog2(STEP + 1);

    state_t          state;
    shift_mode_t     mode_q;
    logic [w-1:0]    data;
    logic [CW-1:0]   count;

    logic [w-1:0]    data_ld;
    logic [CW-1:0]   cnt_ld;
    logic [KW-1:0]   k;
    logic [w-1:0]    shifted;

    // Values as they will be after this edge's loads; start uses these so a
    // load and a start in the same cycle act on the freshly loaded word.
    assign data_ld = ld_data ? bus : data;
    assign cnt_ld  = ld_cnt  ? bus[CW-1:0] : count;

    // k = min(STEP, count). When count < STEP it fits in KW bits.
    always_comb begin
        k = KW'(STEP);
        if (int'(count) < STEP) begin
            k = KW'(count);
        end
    end

    shift_step #(
        .w    (w),
        .STEP (STEP)
    ) u_step (
        .data   (data),
        .k      (k),
        .mode   (mode_q),
        .result (shifted)
    );

    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= SHR;
            data   <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    data  <= data_ld;
                    count <= cnt_ld;
                    if (start) begin
                        if (cnt_ld != '0) begin
                            mode_q <= shift_mode_t'(mode);
                            state  <= SHIFT;
                            busy   <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                // Loads, start and mode are ignored here; nothing is queued.
                SHIFT: begin
                    data  <= shifted;
                    count <= count - CW'(k);
                    if (count == CW'(k)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                // Not busy, so loads still act; start is not honoured until
                // the unit is back in IDLE.
                DONE: begin
                    data  <= data_ld;
                    count <= cnt_ld;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign n         = (count == '0);
    assign tb_shifts = count;

    // With drive and ld_data together the bus carries the old data, so the
    // reload is a harmless no-op.
    assign bus = (drive && !busy) ? data : 'z;

endmodule

// File: tb/tb_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_unit
// Runs a STEP=1 and a STEP=4 shift_unit side by side on identical control
// stimulus (each with its own bus net). Results must agree; busy lengths
// differ as ceil(count/STEP).
// -----------------------------------------------------------------------------
module tb_shift_unit;

    logic        clk_tb = 1'b0;
    logic        rst;
    logic        ld_data, ld_cnt, start, drive;
    logic [1:0]  mode;
    logic        tb_en;
    logic [31:0] tb_val;

    wire  [31:0] bus1, bus4;
    logic        busy1, done1, n1, busy4, done4, n4;
    logic [4:0]  tb_shifts1, tb_shifts4;

    int checks = 0;
    int errors = 0;

    always #5 clk_tb = ~clk_tb;

    assign bus1 = tb_en ? tb_val : 'z;
    assign bus4 = tb_en ? tb_val : 'z;

    shift_unit #(.w(32), .STEP(1)) u_dut1 (
        .clk(clk_tb), .rst(rst), .bus(bus1), .ld_data(ld_data), .ld_cnt(ld_cnt),
        .mode(mode), .start(start), .drive(drive), .busy(busy1), .done(done1),
        .n(n1), .tb_shifts(tb_shifts1)
    );

    shift_unit #(.w(32), .STEP(4)) u_dut4 (
        .clk(clk_tb), .rst(rst), .bus(bus4), .ld_data(ld_data), .ld_cnt(ld_cnt),
        .mode(mode), .start(start), .drive(drive), .busy(busy4), .done(done4),
        .n(n4), .tb_shifts(tb_shifts4)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] cnt;
        logic [1:0]  mode;
        logic [31:0] exp;
        bit          inj;   // pulse loads/start/mode during the first busy cycle
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Loads count then operand over the bus and pulses start. Returns at the
    // negedge right after the start edge.
    task automatic start_op(input logic [31:0] d, input logic [31:0] c, input logic [1:0] m);
        @(negedge clk_tb);
        tb_en = 1'b1; tb_val = c; ld_cnt = 1'b1;
        @(negedge clk_tb);
        ld_cnt = 1'b0; tb_val = d; ld_data = 1'b1;
        @(negedge clk_tb);
        ld_data = 1'b0; tb_en = 1'b0; mode = m; start = 1'b1;
        @(negedge clk_tb);
        start = 1'b0;
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int b1 = 0, b4 = 0, d1 = 0, d4 = 0;
        int exp_b1, exp_b4;
        string tag;
        exp_b1 = int'(v.cnt[4:0]);
        exp_b4 = (exp_b1 + 3) / 4;
        tag    = $sformatf("v%0d", idx);
        start_op(v.data, v.cnt, v.mode);
        for (int i = 0; i < 48; i++) begin
            if (busy1) begin
                check({tag, " count1"}, 32'(tb_shifts1), 32'(exp_b1 - b1));
                check({tag, " n1_busy"}, 32'(n1), 32'd0);
                b1++;
            end
            if (busy4) b4++;
            if (done1) d1++;
            if (done4) d4++;
            if (v.inj && i == 0) begin
                tb_en = 1'b1; tb_val = 32'hFFFF_FFFF;
                ld_data = 1'b1; ld_cnt = 1'b1; start = 1'b1; mode = 2'b10;
            end
            if (v.inj && i == 1) begin
                tb_en = 1'b0; ld_data = 1'b0; ld_cnt = 1'b0; start = 1'b0;
            end
            if (d1 > 0 && d4 > 0 && !done1 && !done4) break;
            @(negedge clk_tb);
        end
        check({tag, " done1_pulses"}, 32'(d1), 32'd1);
        check({tag, " done4_pulses"}, 32'(d4), 32'd1);
        check({tag, " busy1_cycles"}, 32'(b1), 32'(exp_b1));
        check({tag, " busy4_cycles"}, 32'(b4), 32'(exp_b4));
        check({tag, " n1_end"}, 32'(n1), 32'd1);
        check({tag, " n4_end"}, 32'(n4), 32'd1);
        check({tag, " count4_end"}, 32'(tb_shifts4), 32'd0);
        drive = 1'b1;
        #1;
        check({tag, " result1"}, bus1, v.exp);
        check({tag, " result4"}, bus4, v.exp);
        drive = 1'b0;
    endtask

    initial begin
        int dn;
        rst = 1'b1; ld_data = 1'b0; ld_cnt = 1'b0; start = 1'b0; drive = 1'b0;
        mode = 2'b00; tb_en = 1'b0; tb_val = '0;

        //        data           cnt    mode   expected       inj
        vecs[0]  = '{32'h0000_00F0, 32'd5,  2'b00, 32'h0000_0007, 1'b0};
        vecs[1]  = '{32'h8000_0010, 32'd4,  2'b01, 32'hF800_0001, 1'b0};
        vecs[2]  = '{32'h8000_0001, 32'd1,  2'b11, 32'h0000_0003, 1'b0};
        vecs[3]  = '{32'h0000_0001, 32'd9,  2'b10, 32'h0000_0200, 1'b0};
        vecs[4]  = '{32'h1234_5678, 32'd0,  2'b00, 32'h1234_5678, 1'b0};
        vecs[5]  = '{32'hDEAD_BEEF, 32'd32, 2'b10, 32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{32'h8000_0001, 32'd31, 2'b11, 32'hC000_0000, 1'b0};
        vecs[7]  = '{32'h9000_0000, 32'd7,  2'b01, 32'hFF20_0000, 1'b0};
        vecs[8]  = '{32'hFFFF_FFFF, 32'd31, 2'b10, 32'h8000_0000, 1'b0};
        vecs[9]  = '{32'h8000_0000, 32'd31, 2'b00, 32'h0000_0001, 1'b0};
        vecs[10] = '{32'h0000_0F00, 32'd8,  2'b00, 32'h0000_000F, 1'b1};

        @(negedge clk_tb);
        check("reset busy1", 32'(busy1), 32'd0);
        check("reset done1", 32'(done1), 32'd0);
        check("reset n1", 32'(n1), 32'd1);
        check("reset count1", 32'(tb_shifts1), 32'd0);
        check("reset busy4", 32'(busy4), 32'd0);
        check("reset n4", 32'(n4), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(i, vecs[i]);
        end

        // Reset in the middle of a shift: async clear, no done afterwards.
        start_op(32'hFFFF_0000, 32'd10, 2'b00);
        @(negedge clk_tb);
        @(negedge clk_tb);
        check("mid busy1_before", 32'(busy1), 32'd1);
        check("mid busy4_before", 32'(busy4), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid busy1", 32'(busy1), 32'd0);
        check("mid busy4", 32'(busy4), 32'd0);
        check("mid n1", 32'(n1), 32'd1);
        check("mid n4", 32'(n4), 32'd1);
        check("mid count1", 32'(tb_shifts1), 32'd0);
        check("mid done1", 32'(done1), 32'd0);
        @(negedge clk_tb);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_tb);
            if (done1 || done4) dn++;
        end
        check("mid no_done", 32'(dn), 32'd0);
        drive = 1'b1;
        #1;
        check("mid data1", bus1, 32'h0000_0000);
        check("mid data4", bus4, 32'h0000_0000);
        drive = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_unit.md
Name: shift_unit

Overview:
- Multi-cycle shifter for the simple RISC datapath. It is the parametrised successor of the shift-count controller.
- Holds an operand register and a shift-count register, both loaded from the shared tri-state bus.
- Performs logical, arithmetic and rotate shifts of up to STEP bit positions per clock, counting down to zero.
- Drives the result back onto the bus on request. The control unit sequences it through a start/done handshake.

Parameters:
- w, 32: data and bus width (≥ 2).
- STEP, 1: maximum bit positions shifted per clock. Must be a power of two, ≤ w.
- CW, $clog2(w): count register width. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bus  inout  w  shared tri-state datapath bus.
- ld_data  in  1  capture bus into operand register at clk edge.
- ld_cnt  in  1  capture bus[CW-1:0] into count register at clk edge.
- mode  in  2  shift mode, sampled on start.
- start  in  1  begin shifting (single-cycle pulse).
- drive  in  1  drive operand register onto bus.
- busy  out  1  high while shifting.
- done  out  1  one-cycle pulse when result is valid.
- n  out  1  count register == 0.
- tb_shifts  out  CW  current count value, for observation.

Behaviour:
- Reset (async, immediate):
  - data = 0, count = 0, state = IDLE, mode_q = 0.
  - busy = 0, done = 0, n = 1, tb_shifts = 0, bus released (z).
- Mode encoding:
  - 00 SHR: logical right.
  - 01 SHRA: arithmetic right, sign bit replicated.
  - 10 SHL: logical left.
  - 11 SHC: rotate left.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - ld_data and ld_cnt act at the edge. Both may be asserted in the same cycle with the same bus word.
  - On start with count != 0: latch mode into mode_q, go to SHIFT, busy = 1 from the next cycle.
  - On start with count == 0: go to DONE, data unchanged.
  - If ld_* and start occur in the same cycle, the load takes effect and start uses the newly loaded values. Shift begins on the following edge.
- SHIFT:
  - Each edge: k = min(STEP, count). Data is shifted by k per mode_q, and count -= k.
  - When count reaches 0, go to DONE.
  - Latency from the start edge to the done pulse: ceil(c/STEP) + 1 cycles.
- DONE: done = 1 for exactly one cycle, busy = 0, next state IDLE.
- n is combinational (count == 0). tb_shifts = count.
- Ignored while busy:
  - ld_data, ld_cnt, start and mode. They are not queued.
- Bus driving:
  - bus = drive && !busy ? data : 'z.
  - drive while busy leaves the bus released.
  - drive together with ld_data in the same cycle: bus carries the old data. The register reloads the same value; this is legal and a no-op.
- Count semantics:
  - Count is taken modulo w, since only CW bits are loaded.
  - A count of w (e.g. 32) loads as 0: no shift.
- Shift-amount boundaries:
  - SHRA with k up to STEP: fill bits copy data[w-1] as it was before that cycle's shift.
  - SHC: rotation is exact modulo w.
- Reset mid-SHIFT: everything returns to reset values immediately. No done pulse is produced.

Decomposition:
- Package shift_pkg holds:
  - typedef enum logic[1:0] shift_mode_t {SHR, SHRA, SHL, SHC}.
  - typedef enum state_t {IDLE, SHIFT, DONE}.
- One combinational sub-module, shift_step #(w, STEP): (data, k, mode) → shifted data. This is a bounded barrel stage.
- The FSM, registers and bus tri-state logic stay in shift_unit.

Test Plan:
- Reset, then bus = 5 with ld_cnt, bus = 32'h0000_00F0 with ld_data, mode SHR, start:
  - busy for 5 cycles, n goes 0→1 as count decrements 5..0.
  - done pulse, then drive → bus = 32'h0000_0007.
- data 32'h8000_0010, count 4, SHRA → result 32'hF800_0001.
- data 32'h8000_0001, count 1, SHC → result 32'h0000_0003.
- STEP = 4 instance, data 32'h0000_0001, count 9, SHL:
  - busy for exactly 3 cycles (4, 4, 1), result 32'h0000_0200.
- count 0 (or bus = 32 loaded), start → done on the next cycle, data unchanged, busy never asserts.
- Reset asserted mid-shift (count 10, after 3 cycles) → async clear:
  - n = 1, busy = 0, data = 0, no done pulse.
- Also in the same bench: ld_data pulsed during busy is ignored.
